peak_detect: RTL and testbench
==============================

# peak_detect

Frame-based peak detector directly downstream of the magnitude stage. It consumes one unsigned magnitude per `data_in_ready` strobe, tracks the largest magnitude and its bin index over a frame of `FRAME_LEN` bins, and also tracks how many bins exceed a threshold and the frame sum. At the end of each frame it publishes one registered result with a single-cycle `data_out_ready` pulse, which the detection/reporting logic consumes.

## Interface
- `DATA_IN_BITS`, 17, magnitude width; equals the magnitude stage output width.
- `FRAME_LEN`, 1024, bins per frame; must be ≥ 2.
- `INDEX_BITS`, `$clog2(FRAME_LEN)`, bin index width.
- `COUNT_BITS`, `INDEX_BITS + 1`, width of the over-threshold count, so that `FRAME_LEN` is representable.
- `SUM_BITS`, `DATA_IN_BITS + INDEX_BITS`, frame sum width.

Ports (name, direction, width, meaning):
- `clk` input 1: the single clock for the block.
- `rst` input 1: reset, asynchronous and active-low.
- `data_in_ready` input 1: `data_in` is valid this cycle.
- `data_in` input `DATA_IN_BITS`: unsigned magnitude sample.
- `frame_start` input 1: marks bin 0. Only meaningful when `data_in_ready` is high.
- `threshold` input `DATA_IN_BITS`: detection threshold. Sampled on the frame_start sample.
- `data_out_ready` output 1: one-cycle pulse; the result outputs are valid.
- `peak_value` output `DATA_IN_BITS`: largest magnitude in the frame.
- `peak_index` output `INDEX_BITS`: bin index of `peak_value`.
- `over_count` output `COUNT_BITS`: number of bins with `data_in > threshold`.
- `frame_sum` output `SUM_BITS`: sum of all bins in the frame.
- `frame_error` output 1: one-cycle pulse; the current frame was aborted by an early `frame_start`.

## Operation
States: `IDLE` and `ACCUM`.

- **IDLE**
  - Samples arriving without `frame_start` are discarded.
  - A sample with `frame_start` and `data_in_ready` starts a frame and moves to `ACCUM`. That sample becomes bin 0:
    - bin counter = 1
    - working max = `data_in`, working index = 0
    - working sum = `data_in`
    - working count = (`data_in > threshold`)
    - captured threshold = `threshold`
- **ACCUM**: each accepted sample (`data_in_ready` high, `frame_start` low) does the following.
  - Its index is the current bin counter.
  - If `data_in` is strictly greater than the working max, the max and index update. Ties keep the lower index.
  - The sum adds `data_in`; it cannot overflow by construction of `SUM_BITS`.
  - The count increments if `data_in` is greater than the captured threshold.
  - The bin counter increments.
- **Last bin** (counter = `FRAME_LEN-1`, sample accepted):
  - The merged result (working values plus this sample) is written to the output registers.
  - `data_out_ready` pulses.
  - The state returns to `IDLE`, and working registers clear.
- **Gaps:** `data_in_ready` low cycles are allowed anywhere; the state holds.
- **Early restart:** `frame_start` with `data_in_ready` while in `ACCUM`:
  - The current frame is dropped and its outputs are not updated.
  - `frame_error` pulses.
  - The sample is taken as bin 0 of a new frame, as in `IDLE`.
- **Output hold:** result outputs hold their values until the next completed frame overwrites them.
- **Threshold:** changes to `threshold` mid-frame have no effect.

## Timing
- **Reset values** (asynchronous, while `rst` is low):
  - `data_out_ready` = 0, `frame_error` = 0
  - `peak_value` = 0, `peak_index` = 0, `over_count` = 0, `frame_sum` = 0
  - state = `IDLE`; all working registers and the bin counter are 0
- **Reset mid-frame:** the partial frame is lost with no pulse. The first sample after reset release must carry `frame_start`.
- **Latency:** the last sample is sampled at edge k. `data_out_ready` and the results are high/valid in the cycle after edge k and stay valid afterwards. `data_out_ready` deasserts at edge k+1.
- **`frame_error`:** high for exactly the one cycle after the edge that samples the early `frame_start`.
- **Throughput:** one sample per cycle sustained. A new frame_start may arrive in the cycle immediately after the last bin, so back-to-back frames run with no bubble.
- **No backpressure:** the downstream consumer must capture the result on the pulse.

## Structure
- Shared package `magnitude_pkg` holds:
  - the state typedef `peak_state_t` (`IDLE`, `ACCUM`);
  - the default width constants shared with the magnitude stage (`MAG_BITS` = 17).
- One natural sub-module, `peak_compare`: a combinational merge of {max, index} with the {sample, bin} pair, using strict-greater compare.
  - The same unit is reused for both the working update and the final merge.

## Test plan
Bench configuration is `FRAME_LEN` = 8, `DATA_IN_BITS` = 17.

1. Frame {5,9,3,9,1,0,2,7} contiguous, threshold = 4:
   - `data_out_ready` pulses once, 1 cycle after bin 7.
   - Results: peak_value = 9, peak_index = 1 (tie keeps the lower index), over_count = 4, frame_sum = 36.
2. The same frame with random `data_in_ready` gaps and `threshold` changed to 0 mid-frame:
   - Results are identical to scenario 1.
3. A sample without `frame_start`, then a valid frame of all 131071:
   - The stray sample is ignored.
   - Results: peak_index = 0, over_count = 8 at threshold 0, frame_sum = 1048568.
4. Early `frame_start` at bin 5, then a full 8-bin frame {0..7}:
   - `frame_error` pulses once.
   - Results: peak_value = 7, peak_index = 7, over_count = 0 at threshold 7.
5. `rst` driven low at bin 4, released, then a new frame:
   - All outputs are 0 immediately on reset, with no pulse.
   - The next frame reports correctly.
6. Two back-to-back frames with no idle cycle:
   - Two pulses, 8 cycles apart.
   - The second frame's results replace the first's.

Source files
------------

// File: rtl/magnitude_pkg.sv
// Shared types and widths for the magnitude stage
// and the peak detector that consumes its output.
package magnitude_pkg;

  localparam int MAG_BITS = 17;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } peak_state_t;

endpackage

// File: rtl/peak_compare.sv
// Merges a {max, index} pair with a {sample, bin} pair.
// Strict greater-than, so ties keep the earlier bin.
module peak_compare
  import magnitude_pkg::*;
#(
  parameter int DATA_BITS  = MAG_BITS,
  parameter int INDEX_BITS = 10
) (
  input  logic [DATA_BITS-1:0]  cur_max,
  input  logic [INDEX_BITS-1:0] cur_idx,
  input  logic [DATA_BITS-1:0]  sample,
  input  logic [INDEX_BITS-1:0] bin,
  output logic [DATA_BITS-1:0]  new_max,
  output logic [INDEX_BITS-1:0] new_idx
);

  // pick the sample only when it beats the current max
  always_comb begin
    new_max = cur_max;
    new_idx = cur_idx;
    if (sample > cur_max) begin
      new_max = sample;
      new_idx = bin;
    end
  end

endmodule

// File: rtl/peak_detect.sv
// Frame peak detector: max, argmax, over-threshold
// count and sum per frame, one result pulse per frame.
module peak_detect
  import magnitude_pkg::*;
#(
  parameter int DATA_IN_BITS = MAG_BITS,
  parameter int FRAME_LEN    = 1024,
  parameter int INDEX_BITS   = $clog2(FRAME_LEN),
  parameter int COUNT_BITS   = INDEX_BITS + 1,
  parameter int SUM_BITS     = DATA_IN_BITS + INDEX_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_in_ready,
  input  logic [DATA_IN_BITS-1:0] data_in,
  input  logic                    frame_start,
  input  logic [DATA_IN_BITS-1:0] threshold,
  output logic                    data_out_ready,
  output logic [DATA_IN_BITS-1:0] peak_value,
  output logic [INDEX_BITS-1:0]   peak_index,
  output logic [COUNT_BITS-1:0]   over_count,
  output logic [SUM_BITS-1:0]     frame_sum,
  output logic                    frame_error
);

  localparam logic [INDEX_BITS-1:0] LAST_BIN =
    INDEX_BITS'(FRAME_LEN - 1);

  peak_state_t             state;
  logic [INDEX_BITS-1:0]   bin_cnt;
  logic [DATA_IN_BITS-1:0] w_max;
  logic [INDEX_BITS-1:0]   w_idx;
  logic [SUM_BITS-1:0]     w_sum;
  logic [COUNT_BITS-1:0]   w_cnt;
  logic [DATA_IN_BITS-1:0] thr_q;

  logic [DATA_IN_BITS-1:0] m_max;
  logic [INDEX_BITS-1:0]   m_idx;
  logic [SUM_BITS-1:0]     sum_nx;
  logic [COUNT_BITS-1:0]   cnt_nx;
  logic                    start;
  logic                    accept;
  logic                    step;
  logic                    finish;

  // one merge unit feeds both the running state and
  // the published result on the last bin
  peak_compare #(
    .DATA_BITS  (DATA_IN_BITS),
    .INDEX_BITS (INDEX_BITS)
  ) u_cmp (
    .cur_max (w_max),
    .cur_idx (w_idx),
    .sample  (data_in),
    .bin     (bin_cnt),
    .new_max (m_max),
    .new_idx (m_idx)
  );

  // next-value arithmetic and sample classification
  always_comb begin
    sum_nx = w_sum + SUM_BITS'(data_in);
    cnt_nx = w_cnt + COUNT_BITS'(data_in > thr_q);
    start  = data_in_ready & frame_start;
    accept = data_in_ready & ~frame_start
           & (state == ACCUM);
    step   = accept & (bin_cnt != LAST_BIN);
    finish = accept & (bin_cnt == LAST_BIN);
  end

  // frame FSM with working and result registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      bin_cnt        <= '0;
      w_max          <= '0;
      w_idx          <= '0;
      w_sum          <= '0;
      w_cnt          <= '0;
      thr_q          <= '0;
      data_out_ready <= 1'b0;
      frame_error    <= 1'b0;
      peak_value     <= '0;
      peak_index     <= '0;
      over_count     <= '0;
      frame_sum      <= '0;
    end else begin
      data_out_ready <= 1'b0;
      frame_error    <= 1'b0;
      unique case (1'b1)
        start: begin
          frame_error <= (state == ACCUM);
          state       <= ACCUM;
          bin_cnt     <= INDEX_BITS'(1);
          w_max       <= data_in;
          w_idx       <= '0;
          w_sum       <= SUM_BITS'(data_in);
          w_cnt       <= COUNT_BITS'(data_in > threshold);
          thr_q       <= threshold;
        end
        step: begin
          bin_cnt <= bin_cnt + INDEX_BITS'(1);
          w_max   <= m_max;
          w_idx   <= m_idx;
          w_sum   <= sum_nx;
          w_cnt   <= cnt_nx;
        end
        finish: begin
          data_out_ready <= 1'b1;
          peak_value     <= m_max;
          peak_index     <= m_idx;
          over_count     <= cnt_nx;
          frame_sum      <= sum_nx;
          state          <= IDLE;
          bin_cnt        <= '0;
          w_max          <= '0;
          w_idx          <= '0;
          w_sum          <= '0;
          w_cnt          <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_peak_detect.sv
// Scoreboard bench for peak_detect at FRAME_LEN = 8.
// Expected results are queued by the driver, popped on pulses.
module tb_peak_detect;

  localparam int DW = 17;
  localparam int FL = 8;
  localparam int IW = 3;
  localparam int CW = 4;
  localparam int SW = 20;

  typedef struct {
    logic [DW-1:0] pv;
    logic [IW-1:0] pi;
    logic [CW-1:0] oc;
    logic [SW-1:0] fs;
    int            cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          data_in_ready = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          frame_start = 1'b0;
  logic [DW-1:0] threshold = '0;
  logic          data_out_ready;
  logic [DW-1:0] peak_value;
  logic [IW-1:0] peak_index;
  logic [CW-1:0] over_count;
  logic [SW-1:0] frame_sum;
  logic          frame_error;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  exp_t res_q[$];
  int   err_q[$];

  peak_detect #(
    .DATA_IN_BITS (DW),
    .FRAME_LEN    (FL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .data_in_ready  (data_in_ready),
    .data_in        (data_in),
    .frame_start    (frame_start),
    .threshold      (threshold),
    .data_out_ready (data_out_ready),
    .peak_value     (peak_value),
    .peak_index     (peak_index),
    .over_count     (over_count),
    .frame_sum      (frame_sum),
    .frame_error    (frame_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // result monitor
  always @(negedge clk) begin
    if (rst && data_out_ready) begin
      if (res_q.size() == 0) begin
        chk("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = res_q.pop_front();
        chk("pulse_cycle", cyc, e.cyc);
        chk("peak_value", 32'(peak_value), 32'(e.pv));
        chk("peak_index", 32'(peak_index), 32'(e.pi));
        chk("over_count", 32'(over_count), 32'(e.oc));
        chk("frame_sum", 32'(frame_sum), 32'(e.fs));
      end
    end
  end

  // frame_error monitor
  always @(negedge clk) begin
    if (rst && frame_error) begin
      if (err_q.size() == 0) begin
        chk("unexpected_error", 32'd1, 32'd0);
      end else begin
        int c;
        c = err_q.pop_front();
        chk("error_cycle", cyc, c);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic fs,
                      input logic [DW-1:0] d,
                      input logic [DW-1:0] thr);
    data_in_ready = 1'b1;
    frame_start   = fs;
    data_in       = d;
    threshold     = thr;
    @(posedge clk);
    #1;
    data_in_ready = 1'b0;
    frame_start   = 1'b0;
  endtask

  task automatic send_frame(
    input logic [DW-1:0] v[FL],
    input logic [DW-1:0] thr0,
    input logic [DW-1:0] thr_rest,
    input logic          gaps,
    input logic          early,
    input logic [DW-1:0] pv,
    input logic [IW-1:0] pi,
    input logic [CW-1:0] oc,
    input logic [SW-1:0] fs
  );
    exp_t e;
    for (int i = 0; i < FL; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send(i == 0, v[i], (i == 0) ? thr0 : thr_rest);
      if (early && i == 0) err_q.push_back(cyc);
    end
    e.pv  = pv;
    e.pi  = pi;
    e.oc  = oc;
    e.fs  = fs;
    e.cyc = cyc;
    res_q.push_back(e);
  endtask

  logic [DW-1:0] f1[FL] = '{5, 9, 3, 9, 1, 0, 2, 7};
  logic [DW-1:0] fmx[FL] = '{default: 17'd131071};
  logic [DW-1:0] framp[FL] = '{0, 1, 2, 3, 4, 5, 6, 7};
  logic [DW-1:0] f5[FL] = '{1, 2, 3, 4, 8, 6, 5, 4};
  logic [DW-1:0] fa[FL] = '{10, 20, 30, 40, 50, 60, 70, 80};
  logic [DW-1:0] fb[FL] = '{default: 17'd7};

  initial begin
    idle(2);
    chk("rst_ready", 32'(data_out_ready), 32'd0);
    chk("rst_error", 32'(frame_error), 32'd0);
    chk("rst_peak", 32'(peak_value), 32'd0);
    chk("rst_index", 32'(peak_index), 32'd0);
    chk("rst_count", 32'(over_count), 32'd0);
    chk("rst_sum", 32'(frame_sum), 32'd0);
    rst = 1'b1;
    idle(2);

    // 1: contiguous frame
    send_frame(f1, 4, 4, 1'b0, 1'b0, 9, 1, 4, 36);
    idle(3);
    chk("hold_peak", 32'(peak_value), 32'd9);
    chk("hold_sum", 32'(frame_sum), 32'd36);

    // 2: gaps, threshold moved mid-frame
    send_frame(f1, 4, 0, 1'b1, 1'b0, 9, 1, 4, 36);
    idle(3);

    // 3: stray sample, then saturated frame
    send(1'b0, 17'd100, 0);
    idle(1);
    send_frame(fmx, 0, 0, 1'b0, 1'b0,
               17'd131071, 0, 8, 20'd1048568);
    idle(3);

    // 4: early restart at bin 5
    for (int i = 0; i < 5; i++)
      send(i == 0, 17'd50, 0);
    send_frame(framp, 7, 7, 1'b0, 1'b1, 7, 7, 0, 28);
    idle(3);

    // 5: reset mid-frame at bin 4
    for (int i = 0; i < 4; i++)
      send(i == 0, 17'd90, 3);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(data_out_ready), 32'd0);
    chk("mid_rst_peak", 32'(peak_value), 32'd0);
    chk("mid_rst_index", 32'(peak_index), 32'd0);
    chk("mid_rst_count", 32'(over_count), 32'd0);
    chk("mid_rst_sum", 32'(frame_sum), 32'd0);
    idle(2);
    rst = 1'b1;
    idle(1);
    send_frame(f5, 3, 3, 1'b0, 1'b0, 8, 4, 5, 33);
    idle(3);

    // 6: back-to-back frames
    send_frame(fa, 45, 45, 1'b0, 1'b0, 80, 7, 4, 360);
    send_frame(fb, 6, 6, 1'b0, 1'b0, 7, 0, 8, 56);
    idle(4);
    chk("b2b_peak", 32'(peak_value), 32'd7);
    chk("b2b_sum", 32'(frame_sum), 32'd56);

    chk("pending_results", res_q.size(), 0);
    chk("pending_errors", err_q.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
